simu_mem_writer: RTL and testbench

- Loads the simulation memory: takes a stream of data words through a valid/ready handshake and writes them to consecutive memory addresses.
- Each load is started by a single command giving a base address and a word count.
- Drives the memory write port (waddr/wdata/wena) and reports busy, done, progress count and a sticky error.
- It is the write-side counterpart of the memory read-address sequencer and targets the same memory, with the same idle parked address.

---
 rtl/simu_mem_writer_if.sv | 31 +++
 rtl/simu_mem_writer.sv | 118 +++++++++++
 tb/tb_simu_mem_writer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/simu_mem_writer_if.sv
// Stream-in / memory-write bundle for the simulation memory loader.
// The master side issues load commands and data; the slave side owns the write port.
interface simu_mem_writer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        nwords;
    logic              abort;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              wena;
    logic              busy;
    logic              done;
    logic [7:0]        count;
    logic              err;

    modport master (
        output start, base_addr, nwords, abort, in_data, in_valid,
        input  in_ready, waddr, wdata, wena, busy, done, count, err
    );

    modport slave (
        input  start, base_addr, nwords, abort, in_data, in_valid,
        output in_ready, waddr, wdata, wena, busy, done, count, err
    );
endinterface

// File: rtl/simu_mem_writer.sv
// Simulation memory loader: writes a handshaked word stream to consecutive addresses
// starting at a commanded base, with a one-cycle registered write port.
module simu_mem_writer #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    simu_mem_writer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

    localparam logic [ADDR_W-1:0] PARK  = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [32:0]       DEPTH = 33'(MEM_DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [8:0]        remain_q, remain_d;
    logic [7:0]        count_q, count_d;
    logic              err_q, err_d;
    logic              wena_q, wena_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready;
    logic              accept;

    assign ready  = (state_q == LOAD) && !bus.abort;
    assign accept = ready && bus.in_valid;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        count_d  = count_q;
        err_d    = err_q;
        wena_d   = 1'b0;
        waddr_d  = PARK;
        wdata_d  = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (33'(bus.base_addr) < DEPTH) begin
                        addr_d   = bus.base_addr;
                        // nwords of zero encodes a full 256-word load
                        remain_d = (bus.nwords == 8'd0) ? 9'd256 : {1'b0, bus.nwords};
                        count_d  = 8'd0;
                        err_d    = 1'b0;
                        state_d  = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    wena_d   = 1'b1;
                    waddr_d  = addr_q;
                    wdata_d  = bus.in_data;
                    count_d  = count_q + 8'd1;
                    remain_d = remain_q - 9'd1;
                    if (addr_q == PARK) begin
                        addr_d = '0;
                        err_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                    if (remain_q == 9'd1) state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            wena_q   <= 1'b0;
            waddr_q  <= PARK;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            count_q  <= count_d;
            err_q    <= err_d;
            wena_q   <= wena_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.in_ready = ready;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.wena     = wena_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_simu_mem_writer.sv
// Directed and randomized bench for simu_mem_writer against a load-level reference model.
module tb_simu_mem_writer;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int MEM_DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    simu_mem_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    simu_mem_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a load is a list of ml_n words placed at (base + i) mod depth.
    bit ml_active;
    bit ml_fin;
    bit ml_err;
    int ml_acc;
    int ml_n;
    int ml_base;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input bit v, input logic [15:0] d);
        rst = 1'b1;
        bus.in_valid = v; bus.in_data = d; bus.abort = 1'b0;
        bus.start = 1'b0; bus.base_addr = '0; bus.nwords = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        ml_active = 0; ml_fin = 0; ml_err = 0; ml_acc = 0; ml_n = 0; ml_base = 0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_wena",     32'(bus.wena),     32'd0);
        chk("rst_waddr",    32'(bus.waddr),    32'(MEM_DEPTH - 1));
        chk("rst_wdata",    32'(bus.wdata),    32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_done",     32'(bus.done),     32'd0);
        chk("rst_count",    32'(bus.count),    32'd0);
        chk("rst_err",      32'(bus.err),      32'd0);
    endtask

    task automatic tick(input bit v, input logic [15:0] d, input bit ab,
                        input bit st, input logic [15:0] ba, input logic [7:0] nw);
        bit exp_ready, acc, idle_before;
        int exp_addr;
        bus.in_valid = v; bus.in_data = d; bus.abort = ab;
        bus.start = st; bus.base_addr = ba; bus.nwords = nw;
        @(negedge clk);
        exp_ready = ml_active && !ab;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        acc         = v && exp_ready;
        idle_before = !ml_active && !ml_fin;
        exp_addr    = (ml_base + ml_acc) % MEM_DEPTH;
        ml_fin      = 0;
        if (acc) begin
            if (exp_addr == MEM_DEPTH - 1) ml_err = 1;
            ml_acc++;
            if (ml_acc == ml_n) begin
                ml_active = 0;
                ml_fin    = 1;
            end
        end else if (ml_active && ab) begin
            ml_active = 0;
        end
        if (idle_before && st) begin
            if (int'(ba) < MEM_DEPTH) begin
                ml_active = 1;
                ml_base   = int'(ba);
                ml_n      = (nw == 8'd0) ? 256 : int'(nw);
                ml_acc    = 0;
                ml_err    = 0;
            end else begin
                ml_err = 1;
            end
        end
        @(posedge clk); #1;
        chk("wena",  32'(bus.wena),  32'(acc));
        chk("waddr", 32'(bus.waddr), acc ? 32'(exp_addr) : 32'(MEM_DEPTH - 1));
        chk("wdata", 32'(bus.wdata), acc ? 32'(d) : 32'd0);
        chk("busy",  32'(bus.busy),  32'(ml_active || ml_fin));
        chk("done",  32'(bus.done),  32'(ml_fin));
        chk("count", 32'(bus.count), 32'(ml_acc % 256));
        chk("err",   32'(bus.err),   32'(ml_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'd0);
    endtask

    initial begin
        logic [15:0] b;
        int          n;
        do_reset(1'b0, 16'h0);
        idle(1);

        // Basic load with the stream held valid before, during and after.
        tick(1'b1, 16'h00FF, 1'b0, 1'b1, 16'h0010, 8'd4);
        for (int i = 0; i < 4; i++) tick(1'b1, 16'(16'hA0 + i), 1'b0, 1'b0, 16'h0, 8'd0);
        tick(1'b1, 16'h00A4, 1'b0, 1'b0, 16'h0, 8'd0);
        idle(2);

        // Back-pressure pattern 1,0,0,1,0,1.
        b = 16'($urandom_range(0, 1000));
        tick(1'b0, 16'h0, 1'b0, 1'b1, b, 8'd3);
        for (int i = 0; i < 6; i++)
            tick((i == 0) || (i == 3) || (i == 5), 16'($urandom), 1'b0, 1'b0, 16'h0, 8'd0);
        idle(2);

        // Address wrap past the top of memory.
        tick(1'b0, 16'h0, 1'b0, 1'b1, 16'd1022, 8'd4);
        for (int i = 0; i < 5; i++) tick(1'b1, 16'($urandom), 1'b0, 1'b0, 16'h0, 8'd0);
        idle(1);

        // Abort after five handshakes; abort in idle is harmless.
        b = 16'($urandom_range(0, 900));
        tick(1'b0, 16'h0, 1'b0, 1'b1, b, 8'd10);
        for (int i = 0; i < 5; i++) tick(1'b1, 16'($urandom), 1'b0, 1'b0, 16'h0, 8'd0);
        tick(1'b1, 16'h1234, 1'b1, 1'b0, 16'h0, 8'd0);
        tick(1'b1, 16'h5678, 1'b1, 1'b0, 16'h0, 8'd0);
        idle(1);

        // Out-of-range base sets err with no writes; a good start then clears it.
        tick(1'b1, 16'h0, 1'b0, 1'b1, 16'd1024, 8'd2);
        idle(1);
        tick(1'b0, 16'h0, 1'b0, 1'b1, 16'd0, 8'd1);
        tick(1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0, 8'd0);
        idle(2);

        // Start pulses during LOAD and FINISH are ignored.
        tick(1'b0, 16'h0, 1'b0, 1'b1, 16'd100, 8'd2);
        tick(1'b1, 16'($urandom), 1'b0, 1'b1, 16'h0200, 8'd7);
        tick(1'b1, 16'($urandom), 1'b0, 1'b1, 16'h0200, 8'd7);
        tick(1'b0, 16'h0, 1'b0, 1'b1, 16'h0300, 8'd5);
        idle(2);

        // Full 256-word load from a random base.
        b = 16'($urandom_range(0, MEM_DEPTH - 1));
        tick(1'b0, 16'h0, 1'b0, 1'b1, b, 8'd0);
        for (int i = 0; i < 257; i++) tick(1'b1, 16'($urandom), 1'b0, 1'b0, 16'h0, 8'd0);
        idle(1);

        // Randomized loads with sparse valid, rare aborts and stray starts.
        for (int k = 0; k < 4; k++) begin
            b = 16'($urandom_range(0, MEM_DEPTH - 1));
            n = $urandom_range(1, 30);
            tick(1'b0, 16'h0, 1'b0, 1'b1, b, 8'(n));
            for (int c = 0; c < 300 && (ml_active || ml_fin); c++)
                tick(1'($urandom), 16'($urandom), ($urandom % 16) == 0, 1'($urandom),
                     16'($urandom_range(0, MEM_DEPTH - 1)), 8'($urandom));
            idle(1);
        end

        // Reset after two handshakes.
        tick(1'b0, 16'h0, 1'b0, 1'b1, 16'd40, 8'd8);
        tick(1'b1, 16'h1111, 1'b0, 1'b0, 16'h0, 8'd0);
        tick(1'b1, 16'h2222, 1'b0, 1'b0, 16'h0, 8'd0);
        do_reset(1'b1, 16'h3333);
        tick(1'b1, 16'h4444, 1'b0, 1'b0, 16'h0, 8'd0);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
